// File: rtl/level_sequencer.sv
// Game level sequencer: picks random levels, then the maze, tracks lives and wins.
// Ports: clk, resetN (sync, active-low), rand_level, start_game, level_done,
//   player_dead, load_ack in; level_idx, load_req, second_level, playing,
//   lives, levels_cleared, game_over, win out. Define LEVEL_NO_REPEAT_EN to
//   bump a random pick that repeats the previous level.
module level_sequencer #(
  parameter int MAX_RAND           = 6,
  parameter int MAZE_LEVEL         = 7,
  parameter int LEVELS_BEFORE_MAZE = 3,
  parameter int START_LIVES        = 3
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic [3:0] rand_level,
  input  logic       start_game,
  input  logic       level_done,
  input  logic       player_dead,
  input  logic       load_ack,
  output logic [3:0] level_idx,
  output logic       load_req,
  output logic       second_level,
  output logic       playing,
  output logic [1:0] lives,
  output logic [3:0] levels_cleared,
  output logic       game_over,
  output logic       win
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] SELECT = 3'd1;
  localparam logic [2:0] LOAD   = 3'd2;
  localparam logic [2:0] PLAY   = 3'd3;
  localparam logic [2:0] OVER   = 3'd4;

  localparam logic [3:0] MAX_IDX  = 4'(MAX_RAND);
  localparam logic [3:0] MAZE_IDX = 4'(MAZE_LEVEL);
  localparam logic [3:0] N_BEFORE = 4'(LEVELS_BEFORE_MAZE);
  localparam logic [1:0] N_LIVES  = 2'(START_LIVES);

  logic [2:0] state;
  logic [3:0] pick;
  logic       maze_next;

  assign maze_next = (levels_cleared == N_BEFORE);

  // Out-of-range generator values fold to level 0.
  always_comb begin
    pick = (rand_level > MAX_IDX) ? 4'd0 : rand_level;
`ifdef LEVEL_NO_REPEAT_EN
    if (pick == level_idx)
      pick = (pick >= MAX_IDX) ? 4'd0 : pick + 4'd1;
`endif
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state          <= IDLE;
      level_idx      <= 4'd0;
      load_req       <= 1'b0;
      second_level   <= 1'b0;
      playing        <= 1'b0;
      lives          <= 2'd0;
      levels_cleared <= 4'd0;
      game_over      <= 1'b0;
      win            <= 1'b0;
    end else begin
      case (state)
        IDLE, OVER: begin
          if (start_game) begin
            state          <= SELECT;
            lives          <= N_LIVES;
            levels_cleared <= 4'd0;
            second_level   <= 1'b0;
            win            <= 1'b0;
            game_over      <= 1'b0;
          end
        end
        SELECT: begin
          state    <= LOAD;
          load_req <= 1'b1;
          if (maze_next) begin
            level_idx    <= MAZE_IDX;
            second_level <= 1'b1;
          end else begin
            level_idx <= pick;
          end
        end
        LOAD: begin
          if (load_ack) begin
            state    <= PLAY;
            load_req <= 1'b0;
            playing  <= 1'b1;
          end
        end
        PLAY: begin
          // level_done wins over a simultaneous death.
          if (level_done) begin
            playing <= 1'b0;
            if (levels_cleared != 4'd15)
              levels_cleared <= levels_cleared + 4'd1;
            if (second_level) begin
              win       <= 1'b1;
              game_over <= 1'b1;
              state     <= OVER;
            end else begin
              state <= SELECT;
            end
          end else if (player_dead) begin
            playing <= 1'b0;
            if (lives > 2'd1) begin
              lives    <= lives - 2'd1;
              load_req <= 1'b1;
              state    <= LOAD;
            end else begin
              lives     <= 2'd0;
              game_over <= 1'b1;
              state     <= OVER;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_level_sequencer.sv
// Self-checking bench for level_sequencer: directed game scenarios
// followed by random pulses, all compared against a rule-level model.
module tb_level_sequencer;

  logic       clk = 1'b0;
  logic       resetN;
  logic [3:0] rand_level;
  logic       start_game;
  logic       level_done;
  logic       player_dead;
  logic       load_ack;
  logic [3:0] level_idx;
  logic       load_req;
  logic       second_level;
  logic       playing;
  logic [1:0] lives;
  logic [3:0] levels_cleared;
  logic       game_over;
  logic       win;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: game phase plus the bookkeeping the rules talk about.
  typedef enum int {P_IDLE, P_SEL, P_LOAD, P_PLAY, P_OVER} phase_t;
  phase_t m_phase = P_IDLE;
  int m_idx = 0, m_lives = 0, m_cl = 0, m_sec = 0, m_win = 0;

  level_sequencer dut (
    .clk(clk), .resetN(resetN), .rand_level(rand_level),
    .start_game(start_game), .level_done(level_done),
    .player_dead(player_dead), .load_ack(load_ack),
    .level_idx(level_idx), .load_req(load_req),
    .second_level(second_level), .playing(playing), .lives(lives),
    .levels_cleared(levels_cleared), .game_over(game_over), .win(win)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model(input bit rst, input bit st, input bit ld,
                       input bit pd, input bit ack, input int rl);
    int p;
    if (!rst) begin
      m_phase = P_IDLE; m_idx = 0; m_lives = 0;
      m_cl = 0; m_sec = 0; m_win = 0;
      return;
    end
    case (m_phase)
      P_IDLE, P_OVER:
        if (st) begin
          m_lives = 3; m_cl = 0; m_sec = 0; m_win = 0;
          m_phase = P_SEL;
        end
      P_SEL: begin
        if (m_cl == 3) begin
          m_idx = 7; m_sec = 1;
        end else begin
          p = (rl > 6) ? 0 : rl;
`ifdef LEVEL_NO_REPEAT_EN
          if (p == m_idx) p = (p + 1) % 7;
`endif
          m_idx = p;
        end
        m_phase = P_LOAD;
      end
      P_LOAD: if (ack) m_phase = P_PLAY;
      P_PLAY:
        if (ld) begin
          if (m_cl < 15) m_cl++;
          if (m_sec != 0) begin
            m_win = 1; m_phase = P_OVER;
          end else m_phase = P_SEL;
        end else if (pd) begin
          if (m_lives > 1) begin
            m_lives--; m_phase = P_LOAD;
          end else begin
            m_lives = 0; m_phase = P_OVER;
          end
        end
      default: m_phase = P_IDLE;
    endcase
  endtask

  task automatic check_all();
    chk("level_idx", int'(level_idx), m_idx);
    chk("load_req", int'(load_req), int'(m_phase == P_LOAD));
    chk("second_level", int'(second_level), m_sec);
    chk("playing", int'(playing), int'(m_phase == P_PLAY));
    chk("lives", int'(lives), m_lives);
    chk("levels_cleared", int'(levels_cleared), m_cl);
    chk("game_over", int'(game_over), int'(m_phase == P_OVER));
    chk("win", int'(win), m_win);
  endtask

  // One clock: drive, step model at the edge, compare at the falling edge.
  task automatic cyc(input bit rst, input bit st, input bit ld,
                     input bit pd, input bit ack, input int rl);
    resetN = rst; start_game = st; level_done = ld;
    player_dead = pd; load_ack = ack; rand_level = 4'(rl);
    @(posedge clk);
    model(rst, st, ld, pd, ack, rl);
    @(negedge clk);
    check_all();
  endtask

  task automatic go(input bit st, input bit ld, input bit pd,
                    input bit ack, input int rl);
    cyc(1'b1, st, ld, pd, ack, rl);
  endtask

  task automatic new_game(input int rl);
    cyc(1'b0, 0, 0, 0, 0, 0);
    go(1, 0, 0, 0, rl);
    go(0, 0, 0, 0, rl);
    go(0, 0, 0, 1, 0);
  endtask

  initial begin
    int rq;
    resetN = 1'b0; start_game = 0; level_done = 0;
    player_dead = 0; load_ack = 0; rand_level = 0;
    @(negedge clk);
    cyc(1'b0, 0, 0, 0, 0, 0);
    cyc(1'b0, 0, 0, 0, 0, 0);
    chk("rst_lives", int'(lives), 0);
    chk("rst_load_req", int'(load_req), 0);

    // First level: index 4, four-cycle load handshake.
    go(1, 0, 0, 0, 4);
    go(0, 0, 0, 0, 4);
    chk("l4_idx", int'(level_idx), 4);
    rq = int'(load_req);
    for (int i = 0; i < 3; i++) begin
      go(0, 0, 0, 0, 9);
      rq += int'(load_req);
    end
    go(0, 0, 0, 1, 9);
    chk("l4_req_cycles", rq, 4);
    chk("l4_playing", int'(playing), 1);
    chk("l4_lives", int'(lives), 3);

    // Clear three random levels, then the maze.
    for (int i = 0; i < 3; i++) begin
      go(0, 1, 0, 0, 0);
      go(0, 0, 0, 0, 1 + i);
      go(0, 0, 0, 1, 0);
    end
    chk("maze_idx", int'(level_idx), 7);
    chk("maze_sec", int'(second_level), 1);
    go(0, 1, 0, 0, 0);
    chk("maze_over", int'(game_over), 1);
    chk("maze_win", int'(win), 1);
    chk("maze_cleared", int'(levels_cleared), 4);

    // Three deaths reload the same level, then game over.
    go(1, 0, 0, 0, 0);
    go(0, 0, 0, 0, 2);
    go(0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      go(0, 0, 1, 0, 5);
      chk("dead_idx", int'(level_idx), 2);
      chk("dead_lives", int'(lives), 2 - i);
      go(0, 0, 0, 1, 5);
    end
    chk("dead_over", int'(game_over), 1);
    chk("dead_win", int'(win), 0);

    // Simultaneous done + dead on the last life.
    go(1, 0, 0, 0, 0);
    go(0, 0, 0, 0, 1);
    go(0, 0, 0, 1, 0);
    go(0, 0, 1, 0, 0);
    go(0, 0, 0, 1, 0);
    go(0, 0, 1, 0, 0);
    go(0, 0, 0, 1, 0);
    chk("both_lives_before", int'(lives), 1);
    go(0, 1, 1, 0, 0);
    chk("both_cleared", int'(levels_cleared), 1);
    chk("both_lives", int'(lives), 1);
    go(0, 0, 0, 0, 3);
    chk("both_to_load", int'(load_req), 1);

    // Repeat avoidance around level 6.
    new_game(6);
    chk("rep_first", int'(level_idx), 6);
    go(0, 1, 0, 0, 0);
    go(0, 0, 0, 0, 6);
`ifdef LEVEL_NO_REPEAT_EN
    chk("rep_same", int'(level_idx), 0);
`else
    chk("rep_same", int'(level_idx), 6);
`endif
    new_game(6);
    go(0, 1, 0, 0, 0);
    go(0, 0, 0, 0, 9);
    chk("rep_oob", int'(level_idx), 0);

    // Reset in the middle of a load.
    go(0, 0, 0, 1, 0);
    go(0, 1, 0, 0, 0);
    go(0, 0, 0, 0, 5);
    chk("mid_req", int'(load_req), 1);
    cyc(1'b0, 0, 0, 0, 0, 0);
    chk("mid_rst_req", int'(load_req), 0);
    go(0, 0, 0, 1, 0);
    chk("late_ack_req", int'(load_req), 0);
    chk("late_ack_play", int'(playing), 0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 199) != 0,
          $urandom_range(0, 7) == 0,
          $urandom_range(0, 5) == 0,
          $urandom_range(0, 7) == 0,
          $urandom_range(0, 2) == 0,
          int'($urandom_range(0, 15)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
